// File: rtl/axi4_id_inflight_queues.sv
// ============================================================================
// axi4_id_inflight_queues
//
// Per-ID bank of in-flight tracking FIFOs for one AXI4 response channel.
// Each accepted request pushes its tag into the FIFO selected by its ID.
// Each transaction-ending response pops the head of the FIFO for its ID.
// A response whose ID has nothing queued is an orphan. An orphan raises a
// one-cycle error pulse on the following cycle and sets a sticky flag.
//
// Ports:
//   clock        rising-edge clock
//   reset        synchronous, active-high reset
//   req_valid    request issued upstream
//   req_ready    request may be accepted (combinational)
//   req_id       request ID
//   req_tag      tag stored with the request
//   rsp_valid    response completing a transaction (last beat)
//   rsp_id       response ID
//   rsp_hit      response matched a queued entry this cycle (combinational)
//   rsp_tag      head tag of rsp_id, 0 unless rsp_hit
//   id_nonempty  per-ID "holds at least one entry" (registered)
//   id_full      per-ID "holds DEPTH entries" (registered)
//   err_valid    pulse: the previous cycle had an orphan response
//   err_id       ID of the most recent orphan response
//   err_sticky   set on the first orphan, held until reset
// ============================================================================
module axi4_id_inflight_queues #(
    parameter int NUM_IDS = 8,
    parameter int ID_W    = 4,
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [ID_W-1:0]    req_id,
    input  logic [TAG_W-1:0]   req_tag,
    input  logic               rsp_valid,
    input  logic [ID_W-1:0]    rsp_id,
    output logic               rsp_hit,
    output logic [TAG_W-1:0]   rsp_tag,
    output logic [NUM_IDS-1:0] id_nonempty,
    output logic [NUM_IDS-1:0] id_full,
    output logic               err_valid,
    output logic [ID_W-1:0]    err_id,
    output logic               err_sticky
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [PTR_W-1:0]   head_q [NUM_IDS];
    logic [PTR_W-1:0]   head_d [NUM_IDS];
    logic [PTR_W-1:0]   tail_q [NUM_IDS];
    logic [PTR_W-1:0]   tail_d [NUM_IDS];
    logic [CNT_W-1:0]   cnt_q  [NUM_IDS];
    logic [CNT_W-1:0]   cnt_d  [NUM_IDS];
    logic [TAG_W-1:0]   mem_q  [NUM_IDS][DEPTH];

    logic [NUM_IDS-1:0] nonempty_q, nonempty_d;
    logic [NUM_IDS-1:0] full_q, full_d;

    logic               err_valid_q, err_valid_d;
    logic [ID_W-1:0]    err_id_q, err_id_d;
    logic               err_sticky_q, err_sticky_d;

    // ------------------------------------------------------------------
    // ID decode
    // One-hot selects; an ID at or above NUM_IDS decodes to all-zero,
    // which makes it never ready and never a hit.
    // ------------------------------------------------------------------
    logic [NUM_IDS-1:0] req_sel;
    logic [NUM_IDS-1:0] rsp_sel;

    always_comb begin
        req_sel = '0;
        rsp_sel = '0;
        for (int unsigned i = 0; i < NUM_IDS; i++) begin
            if (req_id == ID_W'(i)) req_sel[i] = 1'b1;
            if (rsp_id == ID_W'(i)) rsp_sel[i] = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Handshake, lookup and push/pop strobes
    // ------------------------------------------------------------------
    logic [TAG_W-1:0]   head_tag;
    logic [NUM_IDS-1:0] push_vec;
    logic [NUM_IDS-1:0] pop_vec;
    logic               orphan;

    always_comb begin
        // Readiness and hit use the registered flags. A full FIFO therefore
        // cannot accept a push in the same cycle as it pops. An empty FIFO
        // cannot satisfy a response in the same cycle as it is pushed.
        req_ready = !reset && |(req_sel & ~full_q);
        rsp_hit   = !reset && rsp_valid && |(rsp_sel & nonempty_q);

        head_tag = '0;
        for (int unsigned i = 0; i < NUM_IDS; i++) begin
            if (rsp_sel[i]) head_tag = mem_q[i][head_q[i]];
        end
        rsp_tag = rsp_hit ? head_tag : '0;

        push_vec = {NUM_IDS{req_valid && req_ready}} & req_sel;
        pop_vec  = {NUM_IDS{rsp_hit}} & rsp_sel;
        orphan   = !reset && rsp_valid && !rsp_hit;
    end

    // ------------------------------------------------------------------
    // Next-state for pointers, counts and flags
    // ------------------------------------------------------------------
    always_comb begin
        for (int unsigned i = 0; i < NUM_IDS; i++) begin
            head_d[i] = head_q[i];
            tail_d[i] = tail_q[i];
            cnt_d[i]  = cnt_q[i];

            if (pop_vec[i])  head_d[i] = head_q[i] + PTR_W'(1);
            if (push_vec[i]) tail_d[i] = tail_q[i] + PTR_W'(1);

            case ({push_vec[i], pop_vec[i]})
                2'b10:   cnt_d[i] = cnt_q[i] + CNT_W'(1);
                2'b01:   cnt_d[i] = cnt_q[i] - CNT_W'(1);
                default: cnt_d[i] = cnt_q[i];
            endcase
        end

        nonempty_d = '0;
        full_d     = '0;
        for (int unsigned i = 0; i < NUM_IDS; i++) begin
            nonempty_d[i] = (cnt_d[i] != '0);
            full_d[i]     = (cnt_d[i] == CNT_W'(DEPTH));
        end

        err_valid_d  = orphan;
        err_id_d     = orphan ? rsp_id : err_id_q;
        err_sticky_d = err_sticky_q || orphan;
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_IDS; i++) begin
                head_q[i] <= '0;
                tail_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
            nonempty_q   <= '0;
            full_q       <= '0;
            err_valid_q  <= 1'b0;
            err_id_q     <= '0;
            err_sticky_q <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NUM_IDS; i++) begin
                head_q[i] <= head_d[i];
                tail_q[i] <= tail_d[i];
                cnt_q[i]  <= cnt_d[i];
            end
            nonempty_q   <= nonempty_d;
            full_q       <= full_d;
            err_valid_q  <= err_valid_d;
            err_id_q     <= err_id_d;
            err_sticky_q <= err_sticky_d;
        end
    end

    // Tag storage is not reset. push_vec is already suppressed during reset
    // through req_ready.
    always_ff @(posedge clock) begin
        for (int unsigned i = 0; i < NUM_IDS; i++) begin
            if (push_vec[i]) mem_q[i][tail_q[i]] <= req_tag;
        end
    end

    assign id_nonempty = nonempty_q;
    assign id_full     = full_q;
    assign err_valid   = err_valid_q;
    assign err_id      = err_id_q;
    assign err_sticky  = err_sticky_q;

endmodule

// File: tb/tb_axi4_id_inflight_queues.sv
// ============================================================================
// tb_axi4_id_inflight_queues
//
// Directed steps followed by a randomized traffic phase. Expectations come
// from a reference model that keeps one queue of tags per ID.
// ============================================================================
module tb_axi4_id_inflight_queues;

    localparam int NUM_IDS = 8;
    localparam int ID_W    = 4;
    localparam int DEPTH   = 4;
    localparam int TAG_W   = 8;

    logic               clock = 1'b0;
    logic               reset = 1'b0;
    logic               req_valid = 1'b0;
    logic               req_ready;
    logic [ID_W-1:0]    req_id = '0;
    logic [TAG_W-1:0]   req_tag = '0;
    logic               rsp_valid = 1'b0;
    logic [ID_W-1:0]    rsp_id = '0;
    logic               rsp_hit;
    logic [TAG_W-1:0]   rsp_tag;
    logic [NUM_IDS-1:0] id_nonempty;
    logic [NUM_IDS-1:0] id_full;
    logic               err_valid;
    logic [ID_W-1:0]    err_id;
    logic               err_sticky;

    always #5 clock = ~clock;

    axi4_id_inflight_queues #(
        .NUM_IDS(NUM_IDS),
        .ID_W   (ID_W),
        .DEPTH  (DEPTH),
        .TAG_W  (TAG_W)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_id     (req_id),
        .req_tag    (req_tag),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_hit    (rsp_hit),
        .rsp_tag    (rsp_tag),
        .id_nonempty(id_nonempty),
        .id_full    (id_full),
        .err_valid  (err_valid),
        .err_id     (err_id),
        .err_sticky (err_sticky)
    );

    // Reference model: one queue per ID plus the error reporting state.
    logic [TAG_W-1:0] mq [NUM_IDS][$];
    logic             m_ev;
    logic [ID_W-1:0]  m_eid;
    logic             m_st;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, compare outputs
    // before the next rising edge, then advance the model across that edge.
    task automatic step(input logic rst, input logic qv, input int qid,
                        input logic [TAG_W-1:0] qtag, input logic pv,
                        input int pid, input bit do_chk);
        logic               e_ready;
        logic               e_hit;
        logic [TAG_W-1:0]   e_tag;
        logic [NUM_IDS-1:0] e_ne;
        logic [NUM_IDS-1:0] e_full;

        @(negedge clock);
        reset     = rst;
        req_valid = qv;
        req_id    = ID_W'(qid);
        req_tag   = qtag;
        rsp_valid = pv;
        rsp_id    = ID_W'(pid);
        #1;

        e_ready = 1'b0;
        if (!rst && qid < NUM_IDS) e_ready = (mq[qid].size() < DEPTH);
        e_hit = 1'b0;
        e_tag = '0;
        if (!rst && pv && pid < NUM_IDS) begin
            if (mq[pid].size() > 0) begin
                e_hit = 1'b1;
                e_tag = mq[pid][0];
            end
        end
        for (int i = 0; i < NUM_IDS; i++) begin
            e_ne[i]   = (mq[i].size() > 0);
            e_full[i] = (mq[i].size() == DEPTH);
        end

        if (do_chk) begin
            chk("req_ready",   32'(req_ready),   32'(e_ready));
            chk("rsp_hit",     32'(rsp_hit),     32'(e_hit));
            chk("rsp_tag",     32'(rsp_tag),     32'(e_tag));
            chk("id_nonempty", 32'(id_nonempty), 32'(e_ne));
            chk("id_full",     32'(id_full),     32'(e_full));
            chk("err_valid",   32'(err_valid),   32'(m_ev));
            chk("err_id",      32'(err_id),      32'(m_eid));
            chk("err_sticky",  32'(err_sticky),  32'(m_st));
        end

        if (rst) begin
            for (int i = 0; i < NUM_IDS; i++) mq[i].delete();
            m_ev  = 1'b0;
            m_eid = '0;
            m_st  = 1'b0;
        end else begin
            if (e_hit) void'(mq[pid].pop_front());
            if (qv && e_ready) mq[qid].push_back(qtag);
            m_ev = pv && !e_hit;
            if (m_ev) begin
                m_eid = ID_W'(pid);
                m_st  = 1'b1;
            end
        end
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 0, '0, 1'b0, 0, 1'b1);
    endtask

    task automatic push(input int id, input logic [TAG_W-1:0] tag);
        step(1'b0, 1'b1, id, tag, 1'b0, 0, 1'b1);
    endtask

    task automatic rsp(input int id);
        step(1'b0, 1'b0, 0, '0, 1'b1, id, 1'b1);
    endtask

    initial begin
        m_ev  = 1'b0;
        m_eid = '0;
        m_st  = 1'b0;

        // Reset, then observe the cleared state.
        step(1'b1, 1'b0, 0, '0, 1'b0, 0, 1'b0);
        idle();
        chk("reset_nonempty", 32'(id_nonempty), 32'h0);
        chk("reset_sticky",   32'(err_sticky),  32'h0);

        // Single push and pop on ID 3.
        push(3, 8'hA5);
        rsp(3);
        chk("id3_nonempty", 32'(id_nonempty), 32'h08);
        chk("id3_hit",      32'(rsp_hit),     32'h1);
        chk("id3_tag",      32'(rsp_tag),     32'hA5);
        idle();
        chk("id3_drained",  32'(id_nonempty), 32'h00);
        chk("id3_no_err",   32'(err_valid),   32'h0);

        // Fill and drain ID 5 three times to wrap the pointers.
        for (int rep = 0; rep < 3; rep++) begin
            for (int k = 0; k < DEPTH; k++) push(5, TAG_W'(8'h10 + k));
            step(1'b0, 1'b1, 5, 8'hEE, 1'b0, 0, 1'b1);
            chk("id5_full",     32'(id_full[5]), 32'h1);
            chk("id5_blocked",  32'(req_ready),  32'h0);
            for (int k = 0; k < DEPTH; k++) begin
                rsp(5);
                chk("id5_order", 32'(rsp_tag), 32'(8'h10 + k));
            end
            idle();
            chk("id5_empty", 32'(id_nonempty[5]), 32'h0);
        end

        // Full ID 2: simultaneous push and pop, the push is held off one cycle.
        for (int k = 0; k < DEPTH; k++) push(2, TAG_W'(8'h20 + k));
        step(1'b0, 1'b1, 2, 8'h24, 1'b1, 2, 1'b1);
        chk("id2_pop_hit",  32'(rsp_hit),   32'h1);
        chk("id2_pop_tag",  32'(rsp_tag),   32'h20);
        chk("id2_no_reuse", 32'(req_ready), 32'h0);
        step(1'b0, 1'b1, 2, 8'h24, 1'b0, 0, 1'b1);
        chk("id2_accept",   32'(req_ready), 32'h1);
        idle();
        chk("id2_refull",   32'(id_full[2]), 32'h1);
        for (int k = 0; k < DEPTH; k++) rsp(2);

        // Empty ID 6: push with a same-cycle response, no bypass.
        step(1'b0, 1'b1, 6, 8'h66, 1'b1, 6, 1'b1);
        chk("id6_orphan_hit", 32'(rsp_hit), 32'h0);
        idle();
        chk("id6_err_valid", 32'(err_valid),      32'h1);
        chk("id6_err_id",    32'(err_id),         32'h6);
        chk("id6_sticky",    32'(err_sticky),     32'h1);
        chk("id6_nonempty",  32'(id_nonempty[6]), 32'h1);
        rsp(6);

        // Illegal IDs.
        step(1'b0, 1'b1, 9, 8'h99, 1'b0, 0, 1'b1);
        chk("id9_ready", 32'(req_ready), 32'h0);
        rsp(15);
        chk("idF_hit", 32'(rsp_hit), 32'h0);
        idle();
        chk("idF_err_valid", 32'(err_valid), 32'h1);
        chk("idF_err_id",    32'(err_id),    32'hF);

        // Reset in the middle of traffic discards every queued entry.
        push(0, 8'h01);
        push(0, 8'h02);
        push(7, 8'h71);
        push(7, 8'h72);
        step(1'b1, 1'b1, 0, 8'h77, 1'b1, 7, 1'b1);
        idle();
        chk("mid_reset_nonempty", 32'(id_nonempty), 32'h0);
        chk("mid_reset_sticky",   32'(err_sticky),  32'h0);
        rsp(0);
        chk("post_reset_hit", 32'(rsp_hit), 32'h0);
        idle();
        chk("post_reset_err",    32'(err_valid), 32'h1);
        chk("post_reset_err_id", 32'(err_id),    32'h0);

        // Randomized traffic with occasional illegal IDs and resets.
        for (int n = 0; n < 2000; n++) begin
            logic rst_r;
            logic qv_r;
            logic pv_r;
            int   qid_r;
            int   pid_r;
            rst_r = ($urandom_range(0, 99) == 0);
            qv_r  = ($urandom_range(0, 9) < 6);
            pv_r  = ($urandom_range(0, 9) < 5);
            qid_r = int'($urandom_range(0, 9));
            pid_r = ($urandom_range(0, 15) < 14) ? int'($urandom_range(0, 7))
                                                 : int'($urandom_range(8, 15));
            step(rst_r, qv_r, qid_r, TAG_W'($urandom), pv_r, pid_r, 1'b1);
        end
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/axi4_id_inflight_queues.md
Name: axi4_id_inflight_queues

Overview:
- Per-ID bank of in-flight tracking FIFOs for one AXI4 response channel (R or B).
- On each accepted request, pushes a small request tag into the FIFO for that request's ID. On each response beat that ends a transaction, pops the head entry for that ID.
- Exports per-ID non-empty flags. The response-ID legality checker, which sits directly downstream, requires the non-empty flag of the responding ID to be set whenever a response is valid.
- IDs at or above NUM_IDS are never issued and never legal.

Parameters:
- NUM_IDS, 8: number of implemented IDs; IDs NUM_IDS..2^ID_W-1 are illegal.
- ID_W, 4: ID field width.
- DEPTH, 4: entries per ID FIFO; must be a power of 2 and at least 2.
- TAG_W, 8: width of the stored request tag.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request issued upstream.
- req_ready  out  1  request may be accepted.
- req_id  in  ID_W  ID of the request.
- req_tag  in  TAG_W  tag to store with the request.
- rsp_valid  in  1  response completing a transaction (last beat).
- rsp_id  in  ID_W  ID of the response.
- rsp_hit  out  1  response matched a queued entry this cycle.
- rsp_tag  out  TAG_W  head tag of rsp_id; valid only when rsp_hit=1.
- id_nonempty  out  NUM_IDS  bit i set when FIFO i holds at least 1 entry.
- id_full  out  NUM_IDS  bit i set when FIFO i holds DEPTH entries.
- err_valid  out  1  one-cycle pulse: previous cycle had an orphan response.
- err_id  out  ID_W  ID of the most recent orphan response.
- err_sticky  out  1  set on the first orphan; held until reset.

Behaviour:
- State per ID: head pointer, tail pointer (each log2(DEPTH) bits, wrap modulo DEPTH), count (0..DEPTH, width log2(DEPTH)+1), DEPTH x TAG_W storage.
- Reset (synchronous, one cycle) clears:
  - all counts and pointers;
  - id_nonempty = 0, id_full = 0;
  - err_valid = 0, err_sticky = 0, err_id = 0.
  - Storage is not reset.
  - Reset asserted mid-operation discards every queued entry. Inputs are ignored during the reset cycle, and no push, pop or error is recorded in it.
- req_ready is combinational: (req_id < NUM_IDS) && !id_full[req_id]. It is driven 0 while reset is high.
- Push occurs when req_valid && req_ready:
  - req_tag is written at tail[req_id];
  - tail is incremented and count is incremented at the clock edge.
- rsp_hit is combinational: rsp_valid && (rsp_id < NUM_IDS) && id_nonempty[rsp_id]. It is driven 0 while reset is high.
- rsp_tag is combinational: storage[rsp_id][head[rsp_id]], forced to 0 when rsp_hit=0.
- Pop occurs when rsp_hit=1: head is incremented and count is decremented at the clock edge.
- Orphan response: rsp_valid && !rsp_hit.
  - On the next cycle: err_valid=1 and err_id=rsp_id; err_sticky is set.
  - FIFO state is unchanged.
- Simultaneous push and pop, same ID:
  - FIFO full: pop proceeds; req_ready stays 0 in that cycle because full is evaluated before the edge, so there is no same-cycle reuse. Count becomes DEPTH-1.
  - FIFO empty: there is no push-to-pop bypass. The response is an orphan and the push still happens; count becomes 1.
  - Otherwise: both proceed and count is unchanged.
- Push and pop to different IDs in the same cycle are independent.
- id_nonempty and id_full are registered, derived from the counts (count != 0, count == DEPTH). They update on the edge following a push or pop.
- Latency: 0 cycles from rsp_valid to rsp_hit/rsp_tag. 1 cycle from push to the id_nonempty update.
- No counter overflows: a push to a full FIFO is blocked by req_ready. An illegal req_id is never accepted; the upstream stage stalls.

Test Plan:
- Reset, then push ID 3 tag 0xA5. Next cycle id_nonempty=0x08. Then rsp_valid with ID 3 -> rsp_hit=1, rsp_tag=0xA5; the following cycle id_nonempty=0x00 and err_valid=0.
- Push ID 5 four times with tags 0x10..0x13 -> id_full[5]=1 and req_ready=0 for ID 5. Four responses with ID 5 return 0x10, 0x11, 0x12, 0x13 in order, then id_nonempty[5]=0. Repeat twice to exercise pointer wrap.
- With ID 2 full, drive a push and a pop to ID 2 in the same cycle -> pop returns the head, push is rejected, count=3. Next cycle the push is accepted and count=4.
- rsp_valid with ID 6 while FIFO 6 is empty, with a push to ID 6 in the same cycle -> rsp_hit=0; next cycle err_valid=1, err_id=6, err_sticky=1, id_nonempty[6]=1.
- req_id=9 or rsp_id=0xF -> req_ready=0. For the response: err_valid pulses with err_id=0xF, and no FIFO changes.
- Fill IDs 0 and 7 with 2 entries each, then assert reset for one cycle mid-traffic -> id_nonempty=0, err_sticky=0. A subsequent response with ID 0 is an orphan.
